// File: rtl/mul_share_pkg.sv
// Shared types for the multiplier-sharing controller: operand width, requester
// limit, per-requester state encoding and the issue-pipeline stage record.
package mul_share_pkg;

  localparam int MUL_W       = 32;
  localparam int NUM_REQ_MAX = 4;
  localparam int ID_W        = $clog2(NUM_REQ_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } req_state_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } issue_stage_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester-side bundle: per-requester command handshake with packed operands
// and per-requester response handshake with packed products.
interface mul_share_ctrl_if #(
  parameter int NUM_REQ = 2
);
  import mul_share_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*MUL_W-1:0] req_src1;
  logic [NUM_REQ*MUL_W-1:0] req_src2;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [NUM_REQ*MUL_W-1:0] rsp_result;

  modport master (
    output req_valid, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible index after
// last_grant, wrapping around, and reports it one-hot and encoded.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      // last_grant + k never exceeds 2N-1, so one conditional subtract wraps it
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!grant_any && eligible[cand[IDX_W-1:0]]) begin
        grant[cand[IDX_W-1:0]] = 1'b1;
        grant_idx              = cand[IDX_W-1:0];
        grant_any              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one pipelined 32x32 multiplier among NUM_REQ requesters: round-robin
// issue, ID tracking through the cell latency, one-entry result slot per owner.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  mul_share_ctrl_if.slave  bus,
  output logic [MUL_W-1:0] mul_src1,
  output logic [MUL_W-1:0] mul_src2,
  input  logic [MUL_W-1:0] mul_result,
  output logic             busy
);

  localparam int               IDX_W       = $clog2(NUM_REQ);
  localparam logic [1:0]       ST_IDLE     = IDLE;
  localparam logic [1:0]       ST_INFLIGHT = INFLIGHT;
  localparam logic [1:0]       ST_DONE     = DONE;
  localparam logic [IDX_W-1:0] LAST_RST    = IDX_W'(NUM_REQ - 1);

  logic [1:0]         state [NUM_REQ];
  logic [MUL_W-1:0]   slot  [NUM_REQ];
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] capture;
  issue_stage_t       issue_p [MUL_LATENCY];

  // A DONE requester is not IDLE, so it cannot be re-granted in its drain cycle
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = bus.req_valid[i] && (state[i] == ST_IDLE);
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  assign bus.req_ready = grant;

  always_comb begin
    mul_src1 = '0;
    mul_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mul_src1 = bus.req_src1[MUL_W*i +: MUL_W];
        mul_src2 = bus.req_src2[MUL_W*i +: MUL_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last_grant <= LAST_RST;
    else if (grant_any) last_grant <= grant_idx;
  end

  // Stage 0: issue record enters alongside the operands presented to the cell
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MUL_LATENCY; k++) issue_p[k] <= '0;
    end else begin
      issue_p[0] <= '{vld: grant_any, id: ID_W'(grant_idx)};
      for (int k = 1; k < MUL_LATENCY; k++) issue_p[k] <= issue_p[k-1];
    end
  end

  // Last stage: mul_result now belongs to the owner recorded in the ID
  always_comb begin
    capture = '0;
    for (int i = 0; i < NUM_REQ; i++)
      capture[i] = issue_p[MUL_LATENCY-1].vld && (issue_p[MUL_LATENCY-1].id == ID_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state[i] <= ST_IDLE;
        slot[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case (state[i])
          ST_IDLE:     if (grant[i])           state[i] <= ST_INFLIGHT;
          ST_INFLIGHT: if (capture[i])         state[i] <= ST_DONE;
          ST_DONE:     if (bus.rsp_ready[i])   state[i] <= ST_IDLE;
          default:                             state[i] <= ST_IDLE;
        endcase
        if (capture[i]) slot[i] <= mul_result;
      end
    end
  end

  always_comb begin
    bus.rsp_valid  = '0;
    bus.rsp_result = '0;
    busy           = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i]                   = (state[i] == ST_DONE);
      bus.rsp_result[MUL_W*i +: MUL_W]   = slot[i];
      if (state[i] != ST_IDLE) busy      = 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a behavioural multiplier cell,
// directed corner cases and a randomized multi-requester phase.
module tb_mul_share_ctrl;
  import mul_share_pkg::*;

  localparam int N = 4;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mul_src1, mul_src2, mul_result;
  logic        busy;

  mul_share_ctrl_if #(.NUM_REQ(N)) bus ();

  mul_share_ctrl #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Multiplier cell: L register stages, cleared by the same reset net
  logic [31:0] cell_p [L];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L; k++) cell_p[k] <= '0;
    end else begin
      cell_p[0] <= mul_src1 * mul_src2;
      for (int k = 1; k < L; k++) cell_p[k] <= cell_p[k-1];
    end
  end
  assign mul_result = cell_p[L-1];

  typedef struct { logic [31:0] val; int acc; } exp_t;
  exp_t     exp_q [N][$];
  int       grant_log [$];
  bit       rsp_seen [N];
  int       model_last = N - 1;
  int       checks = 0, errors = 0;
  int       cyc = 0;
  bit [N-1:0] auto_en = '0;
  bit       rand_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [31:0] low_product(logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  // Reference: rotating priority among requesters with valid and nothing outstanding
  always @(negedge clk) begin
    int exp_g, j;
    logic [N-1:0] exp_rdy;
    if (rst) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      model_last = N - 1;
    end else begin
      exp_g = -1;
      for (int k = 1; k <= N; k++) begin
        j = (model_last + k) % N;
        if (exp_g < 0 && bus.req_valid[j] && exp_q[j].size() == 0) exp_g = j;
      end
      exp_rdy = '0;
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (exp_g >= 0) begin
        chk("mul_src1", mul_src1, bus.req_src1[32*exp_g +: 32]);
        chk("mul_src2", mul_src2, bus.req_src2[32*exp_g +: 32]);
        exp_q[exp_g].push_back('{val: low_product(bus.req_src1[32*exp_g +: 32],
                                                  bus.req_src2[32*exp_g +: 32]),
                                 acc: cyc});
        model_last = exp_g;
      end else begin
        chk("mul_src_idle", mul_src1 | mul_src2, 32'd0);
      end
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) grant_log.push_back(i);
    end
  end

  // Response monitor: value, owner, latency, stability and stale responses
  always @(negedge clk) begin
    #2;
    if (rst) begin
      for (int i = 0; i < N; i++) rsp_seen[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.rsp_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL stale_rsp req%0d: got rsp_valid 1 required 0 (cycle %0d)", i, cyc);
          end else begin
            chk($sformatf("rsp_result%0d", i), bus.rsp_result[32*i +: 32], exp_q[i][0].val);
            if (!rsp_seen[i]) begin
              chk($sformatf("rsp_latency%0d", i), 32'(cyc - exp_q[i][0].acc), 32'(L + 1));
              rsp_seen[i] = 1'b1;
            end
            if (bus.rsp_ready[i]) begin
              void'(exp_q[i].pop_front());
              rsp_seen[i] = 1'b0;
            end
          end
        end else if (exp_q[i].size() != 0 &&
                     (rsp_seen[i] || cyc > exp_q[i][0].acc + L + 1)) begin
          checks++; errors++;
          $display("FAIL missing_rsp req%0d: got rsp_valid 0 required 1 (cycle %0d)", i, cyc);
          void'(exp_q[i].pop_front());
          rsp_seen[i] = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] rand_op();
    return ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : $urandom();
  endfunction

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] || !bus.req_valid[i]) begin
        if (auto_en[i] && (!rand_mode || $urandom_range(1, 0) == 1)) begin
          bus.req_valid[i]          = 1'b1;
          bus.req_src1[32*i +: 32]  = rand_op();
          bus.req_src2[32*i +: 32]  = rand_op();
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    if (rand_mode)
      for (int i = 0; i < N; i++) bus.rsp_ready[i] = ($urandom_range(3, 0) != 0);
  endtask

  task automatic issue_one(input int i, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    acc = 1'b0;
    bus.req_valid[i]         = 1'b1;
    bus.req_src1[32*i +: 32] = a;
    bus.req_src2[32*i +: 32] = b;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) acc = 1'b1;
      @(posedge clk); #1;
      if (acc) break;
    end
    bus.req_valid[i] = 1'b0;
    chk($sformatf("issue_accept%0d", i), 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(input int i, output bit ok, output int c);
    ok = 1'b0;
    c  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[i]) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
  endtask

  task automatic drain();
    bit idle;
    auto_en       = '0;
    rand_mode     = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    idle          = 1'b0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clk); #3;
      idle = !busy;
      for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) idle = 1'b0;
    end
    @(posedge clk); #1;
    chk("drain_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required $finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          c0, c1, n1;
    logic [31:0] a, b, bp_exp;

    bus.req_valid = '0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.rsp_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready",  32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    chk("reset_busy",       32'(busy), 32'd0);
    chk("reset_mul_src1",   mul_src1, 32'd0);
    chk("reset_mul_src2",   mul_src2, 32'd0);
    chk("reset_rsp_result", 32'(|bus.rsp_result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention from reset: requester 0 first, then alternation
    grant_log.delete();
    auto_en = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      bus.req_valid[i]         = 1'b1;
      bus.req_src1[32*i +: 32] = rand_op();
      bus.req_src2[32*i +: 32] = rand_op();
    end
    repeat (12) step();
    chk("contention_grants", 32'(grant_log.size() >= 4), 32'd1);
    if (grant_log.size() >= 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("contention_order%0d", k), 32'(grant_log[k]), 32'(k % 2));
    drain();

    // Single op 3 x 5
    bus.req_src1[31:0] = 32'd3;
    bus.req_src2[31:0] = 32'd5;
    bus.req_valid[0]   = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'd1);
    c0 = cyc;
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, ok, c1);
    chk("single_seen", 32'(ok), 32'd1);
    chk("single_latency", 32'(c1 - c0), 32'(L + 1));
    chk("single_result", bus.rsp_result[31:0], 32'd15);
    @(posedge clk); #1;

    // Wrap-around products
    issue_one(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(0, ok, c1);
    chk("wrap_ff_seen", 32'(ok), 32'd1);
    chk("wrap_ff", bus.rsp_result[31:0], 32'h0000_0001);
    @(posedge clk); #1;
    issue_one(1, 32'h0001_0000, 32'h0001_0000);
    wait_rsp(1, ok, c1);
    chk("wrap_2p16_seen", 32'(ok), 32'd1);
    chk("wrap_2p16", bus.rsp_result[63:32], 32'h0000_0000);
    @(posedge clk); #1;
    drain();

    // Backpressure on requester 0 while requester 1 keeps issuing
    bus.rsp_ready[0] = 1'b0;
    a = $urandom();
    b = $urandom();
    bp_exp = low_product(a, b);
    issue_one(0, a, b);
    bus.req_valid[0]   = 1'b1;
    bus.req_src1[31:0] = rand_op();
    bus.req_src2[31:0] = rand_op();
    auto_en = 4'b0010;
    bus.req_valid[1]    = 1'b1;
    bus.req_src1[63:32] = rand_op();
    bus.req_src2[63:32] = rand_op();
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      ok = bus.rsp_valid[0];
    end
    chk("bp_rsp_seen", 32'(ok), 32'd1);
    grant_log.delete();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_rsp_valid",  32'(bus.rsp_valid[0]), 32'd1);
      chk("bp_rsp_result", bus.rsp_result[31:0], bp_exp);
      chk("bp_req_ready0", 32'(bus.req_ready[0]), 32'd0);
    end
    n1 = 0;
    foreach (grant_log[k]) if (grant_log[k] == 1) n1++;
    chk("bp_req1_issued", 32'(n1 >= 2), 32'd1);
    bus.rsp_ready[0] = 1'b1;
    drain();

    // Reset one cycle after an accept discards the in-flight op
    issue_one(1, rand_op(), rand_op());
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_async_busy",      32'(busy), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post_rst_busy",      32'(busy), 32'd0);
    end
    chk("post_rst_result1", bus.rsp_result[63:32], 32'd0);

    // Randomized traffic on all requesters with random response backpressure
    auto_en   = '1;
    rand_mode = 1'b1;
    repeat (400) step();
    drain();
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
